// File: rtl/memory_cycle.sv
// MEM stage of the 5-stage RISC-V pipeline: word load/store over a req/ack data port,
// pipeline stall while an access is outstanding, sticky misalign/timeout flags, MEM/WB register.
module memory_cycle #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RdM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] DMemRData,
  input  logic        DMemAck,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RdW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic        MisalignErr,
  output logic        BusErr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;

  logic access;
  logic aligned;
  logic in_wait;
  logic at_limit;
  logic misalign;
  logic abort;
  logic bubble;
  logic load_done;

  assign access   = MemReadM | MemWriteM;
  assign aligned  = (ALUResultM[1:0] == 2'b00);
  assign in_wait  = (state == WAIT);
  assign at_limit = (cnt == CNT_LIMIT);

  assign DMemAddr  = {ALUResultM[31:2], 2'b00};
  assign DMemWData = WriteDataM;
  assign DMemWe    = MemWriteM;

  assign DMemReq   = in_wait | (access & aligned);
  assign StallM    = (!in_wait & access & aligned & !DMemAck) |
                     (in_wait & !DMemAck & !at_limit);
  assign misalign  = !in_wait & access & !aligned;
  assign abort     = in_wait & !DMemAck & at_limit;
  assign bubble    = StallM | abort | misalign;
  // Ack is only meaningful while a request is on the port
  assign load_done = MemReadM & DMemReq & DMemAck;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access && aligned && !DMemAck) begin
            state <= WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (DMemAck || at_limit) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= 5'd0;
      ALUResultW <= 32'd0;
      ReadDataW  <= 32'd0;
      PCPlus4W   <= 32'd0;
    end else if (bubble) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= 5'd0;
      ALUResultW <= 32'd0;
      ReadDataW  <= 32'd0;
      PCPlus4W   <= 32'd0;
    end else begin
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= load_done ? DMemRData : 32'd0;
      PCPlus4W   <= PCPlus4M;
    end
  end

  // Error flags stay set until the next reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MisalignErr <= 1'b0;
      BusErr      <= 1'b0;
    end else begin
      if (misalign) MisalignErr <= 1'b1;
      if (abort)    BusErr      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Randomized self-checking bench for memory_cycle: a transaction-level model decides, from the
// elapsed cycles of each access and its memory latency, what the port, stall and WB must show.
module tb_memory_cycle;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, MemReadM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, DMemRData;
  logic        DMemAck;
  logic        DMemReq, DMemWe, StallM;
  logic [31:0] DMemAddr, DMemWData;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic        MisalignErr, BusErr;

  int checks = 0;
  int errors = 0;
  int reqCycles;
  int stallCycles;
  logic expMis = 1'b0;
  logic expBus = 1'b0;

  memory_cycle #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .ResultSrcM(ResultSrcM), .RdM(RdM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .DMemRData(DMemRData),
    .DMemAck(DMemAck), .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
    .DMemWData(DMemWData), .StallM(StallM), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .RdW(RdW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .MisalignErr(MisalignErr), .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // kind: 0 = ALU op, 1 = load, 2 = store; latency = cycles after the request before ack
  task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [4:0] rd,
                               input logic rw, input logic [1:0] rs, input logic [31:0] wdata,
                               input logic [31:0] rdataFixed, input bit useFixed, input int latency);
    int e;
    bit done;
    bit isMem, isAligned, wbNormal;
    logic expReq, expStall;
    logic [31:0] rdata, pc4;
    e = 0;
    done = 0;
    reqCycles = 0;
    stallCycles = 0;
    pc4 = $urandom;
    isMem = (kind != 0);
    isAligned = (addr[1:0] == 2'b00);
    RegWriteM = rw; MemWriteM = (kind == 2); MemReadM = (kind == 1);
    ResultSrcM = rs; RdM = rd; ALUResultM = addr; WriteDataM = wdata; PCPlus4M = pc4;
    while (!done) begin
      rdata = useFixed ? rdataFixed : $urandom;
      DMemRData = rdata;
      if (!isMem || !isAligned) DMemAck = 1'($urandom_range(0, 1));
      else DMemAck = (e == latency);
      #2;
      wbNormal = 0;
      expStall = 0;
      expReq = 0;
      if (!isMem) begin
        wbNormal = 1; done = 1;
      end else if (!isAligned) begin
        expMis = 1; done = 1;
      end else begin
        expReq = 1;
        if (e == latency) begin
          wbNormal = 1; done = 1;
        end else if (e == TIMEOUT) begin
          expBus = 1; done = 1;
        end else begin
          expStall = 1;
        end
      end
      checkOutput("DMemReq", 32'(DMemReq), 32'(expReq));
      checkOutput("StallM", 32'(StallM), 32'(expStall));
      if (isMem) begin
        checkOutput("DMemAddr", DMemAddr, {addr[31:2], 2'b00});
        checkOutput("DMemWe", 32'(DMemWe), 32'(kind == 2));
        checkOutput("DMemWData", DMemWData, wdata);
      end
      reqCycles += int'(DMemReq);
      stallCycles += int'(StallM);
      @(posedge clk); #1;
      checkOutput("RegWriteW", 32'(RegWriteW), wbNormal ? 32'(rw) : 32'd0);
      checkOutput("ResultSrcW", 32'(ResultSrcW), wbNormal ? 32'(rs) : 32'd0);
      checkOutput("RdW", 32'(RdW), wbNormal ? 32'(rd) : 32'd0);
      checkOutput("ALUResultW", ALUResultW, wbNormal ? addr : 32'd0);
      checkOutput("PCPlus4W", PCPlus4W, wbNormal ? pc4 : 32'd0);
      checkOutput("ReadDataW", ReadDataW, (wbNormal && kind == 1) ? rdata : 32'd0);
      checkOutput("MisalignErr", 32'(MisalignErr), 32'(expMis));
      checkOutput("BusErr", 32'(BusErr), 32'(expBus));
      e++;
    end
  endtask

  initial begin
    rst = 1'b0;
    RegWriteM = 0; MemWriteM = 0; MemReadM = 0; ResultSrcM = 0; RdM = 0;
    ALUResultM = 0; WriteDataM = 0; PCPlus4M = 0; DMemRData = 0; DMemAck = 0;
    #3;
    checkOutput("rst DMemReq", 32'(DMemReq), 32'd0);
    checkOutput("rst StallM", 32'(StallM), 32'd0);
    checkOutput("rst RegWriteW", 32'(RegWriteW), 32'd0);
    checkOutput("rst ReadDataW", ReadDataW, 32'd0);
    checkOutput("rst MisalignErr", 32'(MisalignErr), 32'd0);
    checkOutput("rst BusErr", 32'(BusErr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Zero-wait load
    applyStimulus(1, 32'h0000_0010, 5'd5, 1'b1, 2'b01, 32'h0, 32'hDEAD_BEEF, 1, 0);
    checkOutput("zw stall cycles", 32'(stallCycles), 32'd0);
    checkOutput("zw ReadDataW", ReadDataW, 32'hDEAD_BEEF);
    // Ack exactly at the timeout limit completes normally
    applyStimulus(1, 32'h0000_0040, 5'd9, 1'b1, 2'b01, 32'h0, 32'hCAFE_F00D, 1, TIMEOUT);
    checkOutput("limit-ack BusErr", 32'(BusErr), 32'd0);
    checkOutput("limit-ack ReadDataW", ReadDataW, 32'hCAFE_F00D);
    // Store acked after 3 wait cycles
    applyStimulus(2, 32'h0000_0020, 5'd0, 1'b0, 2'b00, 32'h1234_5678, 32'h0, 0, 3);
    checkOutput("store req cycles", 32'(reqCycles), 32'd4);
    checkOutput("store stall cycles", 32'(stallCycles), 32'd3);
    // Misaligned load, then a legal one keeps the flag
    applyStimulus(1, 32'h0000_0022, 5'd3, 1'b1, 2'b01, 32'h0, 32'h0, 0, 0);
    applyStimulus(1, 32'h0000_0024, 5'd4, 1'b1, 2'b01, 32'h0, 32'h0, 0, 2);
    // Timeout, then an ALU op writes back
    applyStimulus(1, 32'h0000_0080, 5'd6, 1'b1, 2'b01, 32'h0, 32'h0, 0, 1000);
    checkOutput("timeout req cycles", 32'(reqCycles), 32'd17);
    checkOutput("timeout stall cycles", 32'(stallCycles), 32'd16);
    applyStimulus(0, 32'h0000_1234, 5'd8, 1'b1, 2'b00, 32'h0, 32'h0, 0, 0);

    // Reset while waiting
    RegWriteM = 1; MemReadM = 1; MemWriteM = 0; RdM = 5'd11; ALUResultM = 32'h100; DMemAck = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("wait DMemReq", 32'(DMemReq), 32'd1);
    checkOutput("wait StallM", 32'(StallM), 32'd1);
    #2;
    MemReadM = 0; RegWriteM = 0; RdM = 0; ALUResultM = 0;
    rst = 1'b0;
    expMis = 0; expBus = 0;
    #1;
    checkOutput("midrst DMemReq", 32'(DMemReq), 32'd0);
    checkOutput("midrst StallM", 32'(StallM), 32'd0);
    checkOutput("midrst RegWriteW", 32'(RegWriteW), 32'd0);
    checkOutput("midrst RdW", 32'(RdW), 32'd0);
    checkOutput("midrst ALUResultW", ALUResultW, 32'd0);
    checkOutput("midrst BusErr", 32'(BusErr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus(1, 32'h0000_0200, 5'd7, 1'b1, 2'b01, 32'h0, 32'h0, 0, 1);

    // Random mix of ALU ops, loads and stores
    for (int n = 0; n < 80; n++) begin
      int kind, r, lat;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      if (r < 6) lat = $urandom_range(0, 4);
      else if (r == 6) lat = TIMEOUT;
      else if (r == 7) lat = TIMEOUT - 1;
      else lat = TIMEOUT + 5;
      applyStimulus(kind, a, 5'($urandom), 1'($urandom), 2'($urandom), $urandom, 32'h0, 0, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
